activation_feeder: RTL and testbench

ACTIVATION_FEEDER -- requirements
Module: activation_feeder

---
 rtl/activation_feeder.sv | 154 +++++++++++++++
 tb/tb_activation_feeder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/activation_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// activation_feeder : loads weight rows, then streams activation vectors
//                     into a systolic array with per-lane diagonal skew.
// Revision 1.0
// ---------------------------------------------------------------------------
module activation_feeder #(
   parameter int LANES      = 4,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [LANES*DATA_W-1:0]   w_data,
   input  logic                      a_valid,
   output logic                      a_ready,
   input  logic [LANES*DATA_W-1:0]   a_data,
   input  logic                      a_last,
   output logic                      load_weight,
   output logic [LANES*DATA_W-1:0]   activation_out,
   output logic                      busy,
   output logic                      done
);

   localparam int CNT_MAX = (LANES > GAP_CYCLES) ? LANES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(LANES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'((LANES >= 2) ? LANES - 2 : 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      GAP    = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             w_acc;
   logic             a_acc;

   assign w_ready = (state == LOAD);
   assign a_ready = (state == STREAM);
   assign w_acc   = w_ready && w_valid;
   assign a_acc   = a_ready && a_valid;

   // One counter serves rows in LOAD, idle cycles in GAP and flush cycles in DRAIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         load_weight <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         load_weight <= w_acc;
         done        <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (w_acc) begin
                  if (cnt == ROW_LAST) begin
                     cnt   <= '0;
                     state <= (GAP_CYCLES == 0) ? STREAM : GAP;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= STREAM;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STREAM: begin
               if (a_acc && a_last) begin
                  cnt   <= '0;
                  state <= DRAIN;
                  if (LANES == 1) done <= 1'b1;
               end
            end
            DRAIN: begin
               if (LANES >= 2 && cnt == DONE_AT) done <= 1'b1;
               if (cnt == ROW_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   genvar k;
   generate
      for (k = 0; k < LANES; k++) begin : g_lane
         logic [DATA_W-1:0] lane_in;
         logic [DATA_W-1:0] tail;
         logic [DATA_W-1:0] lane_q;

         // Unaccepted cycles feed zeros so bubbles travel down the diagonal.
         assign lane_in = a_acc ? a_data[k*DATA_W +: DATA_W] : '0;

         if (k == 0) begin : g_direct
            assign tail = lane_in;
         end else begin : g_skew
            logic [DATA_W-1:0] sr [k];
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  for (int j = 0; j < k; j++) sr[j] <= '0;
               end else begin
                  sr[0] <= lane_in;
                  for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
               end
            end
            assign tail = sr[k-1];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lane_q <= '0;
            end else if (state == LOAD) begin
               lane_q <= w_acc ? w_data[k*DATA_W +: DATA_W] : '0;
            end else begin
               lane_q <= tail;
            end
         end

         assign activation_out[k*DATA_W +: DATA_W] = lane_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_activation_feeder.sv
`default_nettype none
// tb_activation_feeder : table-driven load/stream vectors plus corner sequences.
module tb_activation_feeder;
   localparam int LANES  = 4;
   localparam int DATA_W = 8;
   localparam int W      = LANES * DATA_W;

   logic         clk = 1'b0;
   logic         rst, start, w_valid, a_valid, a_last;
   logic [W-1:0] w_data, a_data;
   logic         w_ready, a_ready, load_weight, busy, done;
   logic [W-1:0] activation_out;

   int n_vec = 0;
   int n_bad = 0;

   activation_feeder #(.LANES(LANES), .DATA_W(DATA_W), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
      .load_weight(load_weight), .activation_out(activation_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // flags = {load_weight, busy, done, w_ready, a_ready}
   typedef struct {
      logic         st;
      logic         wv;
      logic [W-1:0] wd;
      logic         av;
      logic [W-1:0] ad;
      logic         al;
      logic [4:0]   flags;
      logic [W-1:0] act;
   } vec_t;

   vec_t tbl [16];

   function automatic logic [4:0] flags_now();
      return {load_weight, busy, done, w_ready, a_ready};
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic st, input logic wv, input logic [W-1:0] wd,
                        input logic av, input logic [W-1:0] ad, input logic al);
      start = st; w_valid = wv; w_data = wd; a_valid = av; a_data = ad; a_last = al;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to_stream();
      int k;
      drive(1, 0, '0, 0, '0, 0); step();
      drive(0, 1, 32'h01000000, 0, '0, 0); step();
      drive(0, 1, 32'h00010000, 0, '0, 0); step();
      drive(0, 1, 32'h00000100, 0, '0, 0); step();
      drive(0, 1, 32'h00000001, 0, '0, 0); step();
      drive(0, 0, '0, 0, '0, 0);
      k = 0;
      while (!a_ready && k < 10) begin
         step();
         k++;
      end
      check("reach_stream", W'(a_ready), W'(1));
   endtask

   initial begin
      tbl[0]  = '{1, 0, 32'h0,        0, 32'h0,        0, 5'b01010, 32'h00000000};
      tbl[1]  = '{0, 1, 32'h01000000, 0, 32'h0,        0, 5'b11010, 32'h01000000};
      tbl[2]  = '{0, 1, 32'h00010000, 0, 32'h0,        0, 5'b11010, 32'h00010000};
      tbl[3]  = '{1, 0, 32'h0,        1, 32'hAAAAAAAA, 1, 5'b01010, 32'h00000000};
      tbl[4]  = '{0, 1, 32'h00000100, 0, 32'h0,        0, 5'b11010, 32'h00000100};
      tbl[5]  = '{0, 1, 32'h00000001, 0, 32'h0,        0, 5'b11000, 32'h00000001};
      tbl[6]  = '{0, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 5'b01000, 32'h00000000};
      tbl[7]  = '{0, 0, 32'h0,        0, 32'h0,        0, 5'b01001, 32'h00000000};
      tbl[8]  = '{1, 0, 32'h0,        1, 32'h01010101, 0, 5'b01001, 32'h00000001};
      tbl[9]  = '{0, 0, 32'h0,        0, 32'h0,        0, 5'b01001, 32'h00000100};
      tbl[10] = '{0, 0, 32'h0,        1, 32'h02020202, 1, 5'b01000, 32'h00010002};
      tbl[11] = '{0, 0, 32'h0,        1, 32'h33333333, 1, 5'b01000, 32'h01000200};
      tbl[12] = '{0, 0, 32'h0,        0, 32'h0,        0, 5'b01000, 32'h00020000};
      tbl[13] = '{0, 0, 32'h0,        0, 32'h0,        0, 5'b01100, 32'h02000000};
      tbl[14] = '{0, 0, 32'h0,        0, 32'h0,        0, 5'b00000, 32'h00000000};
      tbl[15] = '{0, 1, 32'h11111111, 1, 32'h22222222, 0, 5'b00000, 32'h00000000};

      rst = 1'b1;
      drive(0, 0, '0, 0, '0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags", W'(flags_now()), W'(0));
      check("reset_act", activation_out, '0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].st, tbl[i].wv, tbl[i].wd, tbl[i].av, tbl[i].ad, tbl[i].al);
         step();
         check($sformatf("vec%0d_flags", i), W'(flags_now()), W'(tbl[i].flags));
         check($sformatf("vec%0d_act", i), activation_out, tbl[i].act);
      end

      // Back-to-back vectors overlap along the skew diagonal.
      go_to_stream();
      drive(0, 0, '0, 1, 32'h04030201, 0); step();
      check("b2b_t1", activation_out, 32'h00000001);
      drive(0, 0, '0, 1, 32'h08070605, 1); step();
      check("b2b_t2", activation_out, 32'h00000205);
      drive(0, 0, '0, 0, '0, 0); step();
      check("b2b_t3", activation_out, 32'h00030600);
      check("b2b_t3_done", W'(done), W'(0));
      step();
      check("b2b_t4", activation_out, 32'h04070000);
      step();
      check("b2b_t5", activation_out, 32'h08000000);
      check("b2b_t5_done", W'(done), W'(1));
      step();
      check("b2b_t6_flags", W'(flags_now()), W'(0));

      // Asynchronous reset mid-stream discards skewed data.
      go_to_stream();
      drive(0, 0, '0, 1, 32'hA1B2C3D4, 0); step();
      drive(0, 0, '0, 1, 32'h55667788, 0); step();
      check("pre_rst_busy", W'(busy), W'(1));
      #1 rst = 1'b1;
      #1;
      check("rst_async_flags", W'(flags_now()), W'(0));
      check("rst_async_act", activation_out, '0);
      step();
      rst = 1'b0;
      drive(0, 0, '0, 1, 32'h99999999, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_rst%0d_flags", i), W'(flags_now()), W'(0));
         check($sformatf("post_rst%0d_act", i), activation_out, '0);
      end
      drive(1, 0, '0, 0, '0, 0); step();
      check("restart_flags", W'(flags_now()), W'(5'b01010));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
